// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. One shared external full adder does one bit per clock, LSB first.
// The sequencer drives its A/B/Cin inputs and collects its sum and carry outputs.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands; in_ready high; shared adder idle
//   RUN   | one bit per clock through the shared adder, WIDTH cycles
//   DONE  | result presented on sum/cout; waiting for out_ready
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             fa_A,
  output logic             fa_B,
  output logic             fa_Cin,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH:0]   sum_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)               state_d = S_RUN;
      S_RUN:   if (bit_cnt_q == LAST_BIT)  state_d = S_DONE;
      S_DONE:  if (out_ready)              state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    sum_ext   = {fa_sum, sum_sh_q};
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          carry_d   = cin;
          sum_sh_d  = '0;
          bit_cnt_d = '0;
        end
      end
      S_RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        sum_sh_d  = sum_ext[WIDTH:1];
        carry_d   = fa_carry;
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    sum       = sum_sh_q;
    cout      = carry_q;
    fa_A      = 1'b0;
    fa_B      = 1'b0;
    fa_Cin    = 1'b0;
    if (state_q == S_RUN) begin
      fa_A   = a_sh_q[0];
      fa_B   = b_sh_q[0];
      fa_Cin = carry_q;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, each with its own full-adder model.
// Results are checked against plain a+b+cin arithmetic.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, cin, sel;
  logic [7:0] a, b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic       iv8, or8, ir8, ov8, cout8, busy8, faA8, faB8, faC8, fs8, fc8;
  logic [7:0] sum8;
  logic       iv1, or1, ir1, ov1, cout1, busy1, faA1, faB1, faC1, fs1, fc1;
  logic [0:0] sum1;

  assign iv8 = in_valid & ~sel;
  assign or8 = out_ready & ~sel;
  assign iv1 = in_valid & sel;
  assign or1 = out_ready & sel;

  assign fs8 = faA8 ^ faB8 ^ faC8;
  assign fc8 = (faA8 & faB8) | (faA8 & faC8) | (faB8 & faC8);
  assign fs1 = faA1 ^ faB1 ^ faC1;
  assign fc1 = (faA1 & faB1) | (faA1 & faC1) | (faB1 & faC1);

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b), .cin(cin),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .busy(busy8),
    .fa_A(faA8), .fa_B(faB8), .fa_Cin(faC8), .fa_sum(fs8), .fa_carry(fc8)
  );

  serial_add_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a[0:0]), .b(b[0:0]), .cin(cin),
    .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .busy(busy1),
    .fa_A(faA1), .fa_B(faB1), .fa_Cin(faC1), .fa_sum(fs1), .fa_carry(fc1)
  );

  logic       o_in_ready, o_out_valid, o_busy, o_cout, o_faA, o_faB, o_faC;
  logic [7:0] o_sum;
  assign o_in_ready  = sel ? ir1   : ir8;
  assign o_out_valid = sel ? ov1   : ov8;
  assign o_busy      = sel ? busy1 : busy8;
  assign o_cout      = sel ? cout1 : cout8;
  assign o_sum       = sel ? {7'b0, sum1} : sum8;
  assign o_faA       = sel ? faA1  : faA8;
  assign o_faB       = sel ? faB1  : faB8;
  assign o_faC       = sel ? faC1  : faC8;

  // Starts an op on the selected instance (assumed idle) and waits for out_valid.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic ci,
                       output logic [7:0] s, output logic c, output int edges,
                       output logic [7:0] seq);
    int idx;
    idx = 0;
    seq = '0;
    @(negedge clk);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 1;
    @(negedge clk);
    while (!o_out_valid && edges < 100) begin
      if (o_busy && idx < 8) begin
        seq[idx] = o_faA;
        idx++;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    n_checks++;
    if (o_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL op_timeout: out_valid=%b after %0d edges, required 1", o_out_valid, edges);
    end
    s = o_sum;
    c = o_cout;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #3;
      n_checks++;
      if ({o_in_ready, o_out_valid, o_busy, o_sum, o_cout, o_faA, o_faB, o_faC} !== {3'b100, 8'h00, 4'b0000}) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d: ir/ov/busy/sum/cout/fa=%b%b%b/%h/%b/%b%b%b required 100/00/0/000",
                 s, o_in_ready, o_out_valid, o_busy, o_sum, o_cout, o_faA, o_faB, o_faC);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] tv_a [4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] tv_b [4] = '{8'h33, 8'h01, 8'hFF, 8'h00};
    logic       tv_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] s, seq;
    logic       c;
    logic [8:0] exp9;
    int         edges;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_op(tv_a[i], tv_b[i], tv_c[i], s, c, edges, seq);
      exp9 = 9'(tv_a[i]) + 9'(tv_b[i]) + 9'(tv_c[i]);
      n_checks++;
      if ({c, s} !== exp9) begin
        n_fail++;
        $display("FAIL basic_result %h+%h+%b: got %h required %h", tv_a[i], tv_b[i], tv_c[i], {c, s}, exp9);
      end
      if (i == 0) begin
        n_checks++;
        if (edges !== 9) begin
          n_fail++;
          $display("FAIL basic_latency: %0d edges from accept, required 9", edges);
        end
        n_checks++;
        if (seq !== 8'h5A) begin
          n_fail++;
          $display("FAIL basic_fa_A_seq: got %b (LSB first) required %b", seq, 8'h5A);
        end
      end
      @(negedge clk);
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s, seq;
    logic       c;
    int         edges;
    sel = 1'b0;
    do_op(8'hC3, 8'h4E, 1'b1, s, c, edges, seq);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({o_out_valid, o_in_ready, o_cout, o_sum} !== {1'b1, 1'b0, 1'b1, 8'h12}) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc%0d: ov/ir/cout/sum=%b/%b/%b/%h required 1/0/1/12",
                 i, o_out_valid, o_in_ready, o_cout, o_sum);
      end
    end
    release_result();
    n_checks++;
    if ({o_out_valid, o_in_ready, o_sum, o_cout} !== {1'b0, 1'b1, 8'h12, 1'b1}) begin
      n_fail++;
      $display("FAIL backpressure_release: ov/ir/sum/cout=%b/%b/%h/%b required 0/1/12/1",
               o_out_valid, o_in_ready, o_sum, o_cout);
    end
  endtask

  task automatic test_ignore();
    int cyc;
    sel = 1'b0;
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'h11; b = 8'h22; in_valid = 1'b1;
      n_checks++;
      if (o_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_in_ready cyc%0d: got %b required 0", i, o_in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!o_out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if ({o_out_valid, o_cout, o_sum} !== {1'b1, 1'b0, 8'h8D}) begin
      n_fail++;
      $display("FAIL ignore_result: ov/cout/sum=%b/%b/%h required 1/0/8d", o_out_valid, o_cout, o_sum);
    end
    release_result();
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL ignore_no_second_op: busy/ir=%b/%b required 0/1", o_busy, o_in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s, seq;
    logic       c;
    int         edges;
    sel = 1'b0;
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_in_ready, o_out_valid, o_busy, o_faA, o_faB, o_faC, o_sum, o_cout} !== {6'b100000, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: ir/ov/busy/fa/sum/cout=%b/%b/%b/%b%b%b/%h/%b required 1/0/0/000/00/0",
               o_in_ready, o_out_valid, o_busy, o_faA, o_faB, o_faC, o_sum, o_cout);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h10, 8'h20, 1'b0, s, c, edges, seq);
    n_checks++;
    if ({c, s} !== 9'h030) begin
      n_fail++;
      $display("FAIL reset_mid_next_op: got %h required 030", {c, s});
    end
    @(negedge clk);
    release_result();
  endtask

  task automatic test_random(input logic use_w1, input int n_ops);
    logic [7:0] x, y, exp_s;
    logic       ci, exp_c, done;
    logic [8:0] full;
    int         cyc, gap;
    sel = use_w1;
    for (int op = 0; op < n_ops; op++) begin
      x  = 8'($urandom);
      y  = 8'($urandom);
      ci = 1'($urandom);
      if (use_w1) begin
        full  = 9'(x[0]) + 9'(y[0]) + 9'(ci);
        exp_s = {7'b0, full[0]};
        exp_c = full[1];
      end else begin
        full  = 9'(x) + 9'(y) + 9'(ci);
        exp_s = full[7:0];
        exp_c = full[8];
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_faA, o_faB, o_faC} !== 4'b0000) begin
          n_fail++;
          $display("FAIL rand_idle_quiet w1=%b op%0d: busy/fa=%b/%b%b%b required 0/000",
                   use_w1, op, o_busy, o_faA, o_faB, o_faC);
        end
      end
      @(negedge clk);
      a = x; b = y; cin = ci; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (o_out_valid) begin
          n_checks++;
          if ({o_faA, o_faB, o_faC} !== 3'b000) begin
            n_fail++;
            $display("FAIL rand_done_quiet w1=%b op%0d: fa=%b%b%b required 000",
                     use_w1, op, o_faA, o_faB, o_faC);
          end
          if ($urandom_range(0, 1) == 1) begin
            n_checks++;
            if ({o_cout, o_sum} !== {exp_c, exp_s}) begin
              n_fail++;
              $display("FAIL rand_result w1=%b op%0d %h+%h+%b: got %b_%h required %b_%h",
                       use_w1, op, x, y, ci, o_cout, o_sum, exp_c, exp_s);
            end
            release_result();
            done = 1'b1;
          end
        end
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout w1=%b op%0d: no result within 200 cycles", use_w1, op);
      end
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore();
    test_reset_mid();
    test_random(1'b0, 500);
    test_random(1'b1, 500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
